// File: rtl/venda_pkg.sv
// Shared types and widths for the venda sale controller.
package venda_pkg;

  localparam int unsigned COIN_W   = 5;
  localparam int unsigned CREDIT_W = 6;
  localparam int unsigned COUNT_W  = 6;  // counts up to 32 coin reads

  typedef enum logic [2:0] {
    StIdle,
    StReq1,
    StReq2,
    StWait1,
    StWait2,
    StSample,
    StSold,
    StRefund
  } venda_state_t;

endpackage

// File: rtl/venda_if.sv
// Signals between the venda controller, the upstream compra stage and the host.
interface venda_if;
  import venda_pkg::*;

  logic                start;
  logic [COIN_W-1:0]   moeda;
  logic                next;
  logic                vendeu;
  logic                devolve;
  logic [CREDIT_W-1:0] credito;
  logic [CREDIT_W-1:0] troco;
  logic                busy;

  // Environment side: issues start and supplies coins.
  modport master (
    output start, moeda,
    input  next, vendeu, devolve, credito, troco, busy
  );

  // Controller side.
  modport slave (
    input  start, moeda,
    output next, vendeu, devolve, credito, troco, busy
  );

endinterface

// File: rtl/venda.sv
// Sale controller: pulls coins from compra, accumulates credit, sells or refunds.
module venda
  import venda_pkg::*;
#(
  parameter int unsigned PRICE     = 20,
  parameter int unsigned MAX_COINS = 32
) (
  input logic   clk,
  input logic   reset,
  venda_if.slave bus
);

  if (PRICE < 1 || PRICE > 31) begin : g_bad_price
    $error("venda: PRICE must be in 1..31");
  end
  if (MAX_COINS < 1 || MAX_COINS > 32) begin : g_bad_max
    $error("venda: MAX_COINS must be in 1..32");
  end

  localparam logic [CREDIT_W-1:0] PriceC = CREDIT_W'(PRICE);
  localparam logic [COUNT_W-1:0]  MaxC   = COUNT_W'(MAX_COINS);

  venda_state_t        state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] troco_q;
  logic [COUNT_W-1:0]  count_q;
  logic                next_q;
  logic                vendeu_q;
  logic                devolve_q;
  logic                busy_q;

  logic [CREDIT_W-1:0] sum;
  logic [COUNT_W-1:0]  count_inc;

  // Candidate credit and coin count if the sampled coin is accepted; 30 + 31 fits 6 bits.
  always_comb begin
    sum       = credit_q + CREDIT_W'(bus.moeda);
    count_inc = count_q + COUNT_W'(1);
  end

  // Purchase FSM with datapath and registered outputs set alongside each transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      credit_q  <= '0;
      troco_q   <= '0;
      count_q   <= '0;
      next_q    <= 1'b0;
      vendeu_q  <= 1'b0;
      devolve_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q  <= StReq1;
            credit_q <= '0;
            troco_q  <= '0;
            count_q  <= '0;
            next_q   <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StReq1: state_q <= StReq2;
        StReq2: begin
          state_q <= StWait1;
          next_q  <= 1'b0;
        end
        StWait1: state_q <= StWait2;
        StWait2: state_q <= StSample;
        StSample: begin
          if (bus.moeda == '0) begin
            state_q   <= StRefund;
            devolve_q <= 1'b1;
          end else begin
            credit_q <= sum;
            count_q  <= count_inc;
            if (sum >= PriceC) begin
              state_q  <= StSold;
              vendeu_q <= 1'b1;
            end else if (count_inc == MaxC) begin
              state_q   <= StRefund;
              devolve_q <= 1'b1;
            end else begin
              state_q <= StReq1;
              next_q  <= 1'b1;
            end
          end
        end
        StSold: begin
          troco_q  <= credit_q - PriceC;
          vendeu_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        StRefund: begin
          troco_q   <= credit_q;
          devolve_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.next    = next_q;
  assign bus.vendeu  = vendeu_q;
  assign bus.devolve = devolve_q;
  assign bus.credito = credit_q;
  assign bus.troco   = troco_q;
  assign bus.busy    = busy_q;

endmodule
